// File: rtl/gpmc_sync_burst.sv
// Purpose : synchronous muxed-AD GPMC slave with address-incrementing bursts,
//           host stall via gpmc_wait and CPU-side ack handshakes with timeout.
// Latency : cpu_req one cycle after the data-phase edge; read data on AD one
//           cycle after cpu_rd_ack.
// Backpr. : gpmc_wait held high from request until ack or timeout.
// Ports   : clk/reset_n; gpmc_* pad side (AD in/out/oe, adv/cs/we/oe strobes,
//           wait); cpu_* register-file side (req strobe, addr, write data,
//           bit enables, read/write acks); err_count saturating error tally.
module gpmc_sync_burst #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int MAX_BURST   = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] gpmc_ad_i,
   output logic [DATA_WIDTH-1:0] gpmc_ad_o,
   output logic                  gpmc_ad_oe,
   input  logic                  gpmc_adv_n,
   input  logic                  gpmc_cs_n,
   input  logic                  gpmc_we_n,
   input  logic                  gpmc_oe_n,
   output logic                  gpmc_wait,
   output logic                  cpu_req,
   output logic                  cpu_req_is_wr,
   output logic [ADDR_WIDTH:0]   cpu_addr,
   output logic [DATA_WIDTH-1:0] cpu_wr_data,
   output logic [DATA_WIDTH-1:0] cpu_wr_biten,
   input  logic                  cpu_rd_ack,
   input  logic [DATA_WIDTH-1:0] cpu_rd_data,
   input  logic                  cpu_wr_ack,
   output logic [15:0]           err_count
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACTIVE, S_WR_WAIT, S_RD_WAIT, S_RD_PRESENT, S_DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [DATA_WIDTH-1:0] ad_o_q, ad_o_d;
   logic                  wait_q, wait_d;
   logic                  req_q, req_d;
   logic                  req_wr_q, req_wr_d;
   logic [ADDR_WIDTH:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [15:0]           err_q, err_d;
   logic                  drain_adr_q, drain_adr_d;

   logic                  at_max, err_inc, tmo_hit, drain_ack, adr_seen;
   logic [BW-1:0]         beat_inc;
   logic [ADDR_WIDTH:0]   addr_cur, addr_inc;

   // beat saturates at MAX_BURST so every host beat past the limit is an overrun
   assign at_max   = (beat_q == BEAT_MAX);
   assign beat_inc = at_max ? beat_q : beat_q + BW'(1);
   assign addr_cur = {base_q + ADDR_WIDTH'(beat_q), 1'b0};
   assign addr_inc = {base_q + ADDR_WIDTH'(beat_inc), 1'b0};
   assign tmo_hit  = (tmo_q == TMO_LAST);
   assign adr_seen = !gpmc_cs_n && !gpmc_adv_n;
   // req_wr_q still remembers the kind of the abandoned request
   assign drain_ack = req_wr_q ? cpu_wr_ack : cpu_rd_ack;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      beat_d      = beat_q;
      tmo_d       = tmo_q;
      ad_o_d      = ad_o_q;
      wait_d      = wait_q;
      req_d       = 1'b0;
      req_wr_d    = req_wr_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      drain_adr_d = drain_adr_q;
      err_inc     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (adr_seen) begin
               base_d  = gpmc_ad_i[ADDR_WIDTH-1:0];
               beat_d  = '0;
               state_d = S_ACTIVE;
            end
         end

         S_ACTIVE: begin
            if (gpmc_cs_n) begin
               state_d = S_IDLE;
            end else if (!gpmc_adv_n) begin
               base_d = gpmc_ad_i[ADDR_WIDTH-1:0];
               beat_d = '0;
            end else if (!gpmc_we_n && !gpmc_oe_n) begin
               err_inc = 1'b1;
            end else if (!gpmc_we_n) begin
               if (at_max) begin
                  err_inc = 1'b1;
               end else begin
                  req_d     = 1'b1;
                  req_wr_d  = 1'b1;
                  addr_d    = addr_cur;
                  wr_data_d = gpmc_ad_i;
                  wait_d    = 1'b1;
                  tmo_d     = '0;
                  state_d   = S_WR_WAIT;
               end
            end else if (!gpmc_oe_n) begin
               if (at_max) begin
                  err_inc = 1'b1;
                  ad_o_d  = '1;
                  wait_d  = 1'b0;
                  state_d = S_RD_PRESENT;
               end else begin
                  req_d    = 1'b1;
                  req_wr_d = 1'b0;
                  addr_d   = addr_cur;
                  wait_d   = 1'b1;
                  tmo_d    = '0;
                  state_d  = S_RD_WAIT;
               end
            end
         end

         S_WR_WAIT: begin
            // ack wins over a timeout on the same edge
            if (cpu_wr_ack || tmo_hit) begin
               err_inc = !cpu_wr_ack;
               beat_d  = beat_inc;
               wait_d  = 1'b0;
               state_d = gpmc_cs_n ? S_IDLE : S_ACTIVE;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (gpmc_cs_n) begin
                  drain_adr_d = 1'b0;
                  state_d     = S_DRAIN;
               end
            end
         end

         S_RD_WAIT: begin
            if (cpu_rd_ack || tmo_hit) begin
               err_inc = !cpu_rd_ack;
               ad_o_d  = cpu_rd_ack ? cpu_rd_data : '1;
               wait_d  = 1'b0;
               state_d = gpmc_cs_n ? S_IDLE : S_RD_PRESENT;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (gpmc_cs_n) begin
                  drain_adr_d = 1'b0;
                  state_d     = S_DRAIN;
               end
            end
         end

         S_RD_PRESENT: begin
            // this edge is where the host consumes the presented word
            beat_d = beat_inc;
            if (gpmc_cs_n) begin
               state_d = S_IDLE;
            end else if (!gpmc_adv_n) begin
               base_d  = gpmc_ad_i[ADDR_WIDTH-1:0];
               beat_d  = '0;
               state_d = S_ACTIVE;
            end else if (!gpmc_oe_n) begin
               if (beat_inc == BEAT_MAX) begin
                  err_inc = 1'b1;
                  ad_o_d  = '1;
               end else begin
                  req_d    = 1'b1;
                  req_wr_d = 1'b0;
                  addr_d   = addr_inc;
                  wait_d   = 1'b1;
                  tmo_d    = '0;
                  state_d  = S_RD_WAIT;
               end
            end else begin
               state_d = S_ACTIVE;
            end
         end

         S_DRAIN: begin
            // wait stays high; the abandoned request is retired silently
            if (adr_seen) begin
               base_d      = gpmc_ad_i[ADDR_WIDTH-1:0];
               beat_d      = '0;
               drain_adr_d = 1'b1;
            end
            if (drain_ack || tmo_hit) begin
               wait_d  = 1'b0;
               state_d = drain_adr_d ? S_ACTIVE : S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      err_d = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         beat_q      <= '0;
         tmo_q       <= '0;
         ad_o_q      <= '0;
         wait_q      <= 1'b0;
         req_q       <= 1'b0;
         req_wr_q    <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         err_q       <= '0;
         drain_adr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         beat_q      <= beat_d;
         tmo_q       <= tmo_d;
         ad_o_q      <= ad_o_d;
         wait_q      <= wait_d;
         req_q       <= req_d;
         req_wr_q    <= req_wr_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         err_q       <= err_d;
         drain_adr_q <= drain_adr_d;
      end
   end

   assign gpmc_ad_oe    = !gpmc_cs_n && !gpmc_oe_n;
   assign gpmc_ad_o     = ad_o_q;
   assign gpmc_wait     = wait_q;
   assign cpu_req       = req_q;
   assign cpu_req_is_wr = req_wr_q;
   assign cpu_addr      = addr_q;
   assign cpu_wr_data   = wr_data_q;
   assign cpu_wr_biten  = '1;
   assign err_count     = err_q;

endmodule

// File: tb/tb_gpmc_sync_burst.sv
// Purpose : directed checks of gpmc_sync_burst: single write, read burst,
//           address wrap, overrun, ack timeout, cs_n abort and async reset.
// Latency : n/a (testbench)
// Backpr. : n/a (testbench)
module tb_gpmc_sync_burst;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] gpmc_ad_i;
   logic [15:0] gpmc_ad_o;
   logic        gpmc_ad_oe;
   logic        gpmc_adv_n, gpmc_cs_n, gpmc_we_n, gpmc_oe_n;
   logic        gpmc_wait;
   logic        cpu_req, cpu_req_is_wr;
   logic [16:0] cpu_addr;
   logic [15:0] cpu_wr_data, cpu_wr_biten;
   logic        cpu_rd_ack, cpu_wr_ack;
   logic [15:0] cpu_rd_data;
   logic [15:0] err_count;

   int n_chk = 0;
   int n_bad = 0;
   int exp_err = 0;

   gpmc_sync_burst dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .gpmc_ad_i    (gpmc_ad_i),
      .gpmc_ad_o    (gpmc_ad_o),
      .gpmc_ad_oe   (gpmc_ad_oe),
      .gpmc_adv_n   (gpmc_adv_n),
      .gpmc_cs_n    (gpmc_cs_n),
      .gpmc_we_n    (gpmc_we_n),
      .gpmc_oe_n    (gpmc_oe_n),
      .gpmc_wait    (gpmc_wait),
      .cpu_req      (cpu_req),
      .cpu_req_is_wr(cpu_req_is_wr),
      .cpu_addr     (cpu_addr),
      .cpu_wr_data  (cpu_wr_data),
      .cpu_wr_biten (cpu_wr_biten),
      .cpu_rd_ack   (cpu_rd_ack),
      .cpu_rd_data  (cpu_rd_data),
      .cpu_wr_ack   (cpu_wr_ack),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic [15:0] a);
      gpmc_cs_n  = 1'b0;
      gpmc_adv_n = 1'b0;
      gpmc_ad_i  = a;
      step();
      gpmc_adv_n = 1'b1;
   endtask

   task automatic end_cycle();
      gpmc_cs_n = 1'b1;
      gpmc_we_n = 1'b1;
      gpmc_oe_n = 1'b1;
      step();
   endtask

   // one write beat acked in the request cycle
   task automatic wr_beat(input logic [15:0] d, input logic [31:0] exp_addr);
      gpmc_we_n = 1'b0;
      gpmc_ad_i = d;
      step();
      chk("wr_req", cpu_req, 1);
      chk("wr_is_wr", cpu_req_is_wr, 1);
      chk("wr_addr", cpu_addr, exp_addr);
      chk("wr_data", cpu_wr_data, d);
      gpmc_we_n  = 1'b1;
      cpu_wr_ack = 1'b1;
      step();
      cpu_wr_ack = 1'b0;
      chk("wr_done_wait", gpmc_wait, 0);
   endtask

   initial begin
      int n;
      reset_n     = 1'b0;
      gpmc_ad_i   = '0;
      gpmc_adv_n  = 1'b1;
      gpmc_cs_n   = 1'b1;
      gpmc_we_n   = 1'b1;
      gpmc_oe_n   = 1'b1;
      cpu_rd_ack  = 1'b0;
      cpu_wr_ack  = 1'b0;
      cpu_rd_data = '0;
      repeat (3) step();

      // reset state
      chk("rst_ad_o", gpmc_ad_o, 0);
      chk("rst_wait", gpmc_wait, 0);
      chk("rst_req", cpu_req, 0);
      chk("rst_addr", cpu_addr, 0);
      chk("rst_wr_data", cpu_wr_data, 0);
      chk("rst_err", err_count, 0);
      chk("rst_oe", gpmc_ad_oe, 0);
      chk("biten", cpu_wr_biten, 16'hFFFF);
      reset_n = 1'b1;
      step();

      // single write, ack one cycle after the request cycle
      addr_phase(16'h0010);
      gpmc_we_n = 1'b0;
      gpmc_ad_i = 16'hBEEF;
      step();
      chk("w1_req", cpu_req, 1);
      chk("w1_is_wr", cpu_req_is_wr, 1);
      chk("w1_addr", cpu_addr, 17'h00020);
      chk("w1_data", cpu_wr_data, 16'hBEEF);
      chk("w1_wait", gpmc_wait, 1);
      gpmc_we_n = 1'b1;
      step();
      chk("w1_req_strobe", cpu_req, 0);
      chk("w1_wait_hold", gpmc_wait, 1);
      cpu_wr_ack = 1'b1;
      step();
      cpu_wr_ack = 1'b0;
      chk("w1_wait_rel", gpmc_wait, 0);
      chk("w1_err", err_count, exp_err);
      end_cycle();

      // 4-beat read burst, ack 3 cycles after each request
      addr_phase(16'h0100);
      gpmc_oe_n = 1'b0;
      step();
      chk("r_oe", gpmc_ad_oe, 1);
      for (int i = 0; i < 4; i++) begin
         chk("r_req", cpu_req, 1);
         chk("r_is_wr", cpu_req_is_wr, 0);
         chk("r_addr", cpu_addr, 32'h200 + 32'(2 * i));
         step();
         step();
         chk("r_req_strobe", cpu_req, 0);
         chk("r_wait", gpmc_wait, 1);
         step();
         cpu_rd_ack  = 1'b1;
         cpu_rd_data = 16'(16'h1111 * (i + 1));
         step();
         cpu_rd_ack = 1'b0;
         chk("r_ad", gpmc_ad_o, 32'(16'h1111 * (i + 1)));
         chk("r_wait_low", gpmc_wait, 0);
         if (i == 3) gpmc_oe_n = 1'b1;
         step();
      end
      chk("r_end_wait", gpmc_wait, 0);
      chk("r_end_req", cpu_req, 0);
      end_cycle();

      // address wrap across 0xFFFF
      addr_phase(16'hFFFF);
      wr_beat(16'hA001, 32'h1FFFE);
      wr_beat(16'hA002, 32'h00000);
      // we_n and oe_n low together
      gpmc_we_n = 1'b0;
      gpmc_oe_n = 1'b0;
      step();
      gpmc_we_n = 1'b1;
      gpmc_oe_n = 1'b1;
      exp_err++;
      chk("both_low_req", cpu_req, 0);
      chk("both_low_err", err_count, exp_err);
      end_cycle();

      // overrun: 9 write beats, 8 requests
      addr_phase(16'h0040);
      for (int i = 0; i < 8; i++) wr_beat(16'(16'h5000 + i), 32'h80 + 32'(2 * i));
      gpmc_we_n = 1'b0;
      gpmc_ad_i = 16'h5008;
      step();
      gpmc_we_n = 1'b1;
      exp_err++;
      chk("ovr_req", cpu_req, 0);
      chk("ovr_wait", gpmc_wait, 0);
      chk("ovr_err", err_count, exp_err);
      end_cycle();

      // read timeout
      addr_phase(16'h0300);
      gpmc_oe_n = 1'b0;
      step();
      chk("tmo_req", cpu_req, 1);
      n = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (!gpmc_wait) begin
            n = k;
            break;
         end
      end
      exp_err++;
      chk("tmo_cycles", n, 64);
      chk("tmo_ad", gpmc_ad_o, 16'hFFFF);
      chk("tmo_err", err_count, exp_err);
      gpmc_oe_n   = 1'b1;
      cpu_rd_ack  = 1'b1;
      cpu_rd_data = 16'h1234;
      step();
      cpu_rd_ack = 1'b0;
      chk("late_ack_ad", gpmc_ad_o, 16'hFFFF);
      chk("late_ack_err", err_count, exp_err);
      chk("late_ack_wait", gpmc_wait, 0);
      end_cycle();

      // abort: cs_n high during RD_WAIT
      addr_phase(16'h0500);
      gpmc_oe_n = 1'b0;
      step();
      chk("ab_req", cpu_req, 1);
      gpmc_cs_n = 1'b1;
      gpmc_oe_n = 1'b1;
      step();
      chk("ab_wait1", gpmc_wait, 1);
      step();
      chk("ab_wait2", gpmc_wait, 1);
      cpu_rd_ack  = 1'b1;
      cpu_rd_data = 16'hABCD;
      step();
      cpu_rd_ack = 1'b0;
      chk("ab_wait_rel", gpmc_wait, 0);
      chk("ab_err", err_count, exp_err);
      // in IDLE a data-phase strobe without an address is ignored
      gpmc_cs_n = 1'b0;
      gpmc_we_n = 1'b0;
      step();
      chk("ab_idle_noreq", cpu_req, 0);
      end_cycle();

      // asynchronous reset mid-burst
      addr_phase(16'h0010);
      gpmc_we_n = 1'b0;
      gpmc_ad_i = 16'h7777;
      step();
      chk("ar_pre_req", cpu_req, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_req", cpu_req, 0);
      chk("ar_wait", gpmc_wait, 0);
      chk("ar_addr", cpu_addr, 0);
      chk("ar_wr_data", cpu_wr_data, 0);
      chk("ar_ad_o", gpmc_ad_o, 0);
      chk("ar_err", err_count, 0);
      step();
      cpu_wr_ack = 1'b1;
      reset_n    = 1'b1;
      step();
      cpu_wr_ack = 1'b0;
      chk("ar_post_wait", gpmc_wait, 0);
      chk("ar_post_req", cpu_req, 0);
      chk("ar_post_err", err_count, 0);
      end_cycle();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
